shift_pipe: RTL

//  Parametrised, two-stage pipelined barrel shifter. Successor to the fixed 8-bit LSL unit.

---
 rtl/shift_pipe_pkg.sv | 11 +
 rtl/shift_pipe_core.sv | 68 ++++++
 rtl/shift_pipe.sv | 92 +++++++++
 3 files changed

// File: rtl/shift_pipe_pkg.sv
// Shared definitions for the shift_pipe barrel shifter: operation encodings.
package shift_pipe_pkg;

    typedef enum logic [1:0] {
        OP_LSL = 2'b00,
        OP_LSR = 2'b01,
        OP_ASR = 2'b10,
        OP_ROR = 2'b11
    } shift_op_e;

endpackage

// File: rtl/shift_pipe_core.sv
// Combinational log-stage barrel shifter: stage k shifts by 2^k when shamt[k] is set,
// carrying the last bit shifted out through the chain.
module shift_core
    import shift_pipe_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0]   i_d,
    input  logic [SHAMT_W-1:0] i_shamt,
    input  shift_op_e          i_op,
    output logic [WIDTH-1:0]   o_d,
    output logic               o_carry
);

    logic [WIDTH-1:0] w_final;
    logic             w_final_c;

    for (genvar k = 0; k < SHAMT_W; k++) begin : g_stage
        localparam int SH = 1 << k;
        logic [WIDTH-1:0] w_in;
        logic [WIDTH-1:0] w_out;
        logic             w_cin;
        logic             w_cout;

        if (k == 0) begin : g_first
            assign w_in  = i_d;
            assign w_cin = 1'b0;
        end else begin : g_next
            assign w_in  = g_stage[k-1].w_out;
            assign w_cin = g_stage[k-1].w_cout;
        end

        // The last active stage's outgoing edge bit is the overall last bit shifted out.
        always_comb begin
            w_out  = w_in;
            w_cout = w_cin;
            if (i_shamt[k]) begin
                unique case (i_op)
                    OP_LSL: begin
                        w_out  = {w_in[WIDTH-SH-1:0], {SH{1'b0}}};
                        w_cout = w_in[WIDTH-SH];
                    end
                    OP_LSR: begin
                        w_out  = {{SH{1'b0}}, w_in[WIDTH-1:SH]};
                        w_cout = w_in[SH-1];
                    end
                    OP_ASR: begin
                        w_out  = {{SH{w_in[WIDTH-1]}}, w_in[WIDTH-1:SH]};
                        w_cout = w_in[SH-1];
                    end
                    OP_ROR: begin
                        w_out  = {w_in[SH-1:0], w_in[WIDTH-1:SH]};
                        w_cout = w_cin;
                    end
                endcase
            end
        end
    end

    assign w_final   = g_stage[SHAMT_W-1].w_out;
    assign w_final_c = g_stage[SHAMT_W-1].w_cout;

    // Rotation loses no bits, so its carry is the new MSB (only when actually rotating).
    assign o_d     = w_final;
    assign o_carry = (i_op == OP_ROR) ? ((i_shamt != '0) && w_final[WIDTH-1]) : w_final_c;

endmodule

// File: rtl/shift_pipe.sv
// Two-stage pipelined barrel shifter with valid/ready handshakes on both sides.
// Stage 1 holds the operation, stage 2 holds the result and flags.
module shift_pipe
    import shift_pipe_pkg::*;
#(
    parameter  int WIDTH   = 8,
    localparam int SHAMT_W = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   d_in,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic [1:0]         op,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   d_out,
    output logic               carry,
    output logic               zero
);

    logic               r_s1_valid;
    logic [WIDTH-1:0]   r_s1_d;
    logic [SHAMT_W-1:0] r_s1_shamt;
    shift_op_e          r_s1_op;

    logic               r_s2_valid;
    logic [WIDTH-1:0]   r_s2_d;
    logic               r_s2_carry;
    logic               r_s2_zero;

    logic [WIDTH-1:0]   w_res;
    logic               w_res_c;
    logic               w_adv1;
    logic               w_adv2;

    // No skid buffer: readiness ripples combinationally back from out_ready.
    assign w_adv2   = !r_s2_valid || out_ready;
    assign w_adv1   = !r_s1_valid || w_adv2;
    assign in_ready = w_adv1;

    shift_core #(
        .WIDTH   (WIDTH),
        .SHAMT_W (SHAMT_W)
    ) u_core (
        .i_d     (r_s1_d),
        .i_shamt (r_s1_shamt),
        .i_op    (r_s1_op),
        .o_d     (w_res),
        .o_carry (w_res_c)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_s1_valid <= 1'b0;
            r_s1_d     <= '0;
            r_s1_shamt <= '0;
            r_s1_op    <= OP_LSL;
        end else if (w_adv1) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_d     <= d_in;
                r_s1_shamt <= shamt;
                r_s1_op    <= shift_op_e'(op);
            end
        end
    end

    // Result registers only load on a real op, so they hold while stalled.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_s2_valid <= 1'b0;
            r_s2_d     <= '0;
            r_s2_carry <= 1'b0;
            r_s2_zero  <= 1'b0;
        end else if (w_adv2) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_d     <= w_res;
                r_s2_carry <= w_res_c;
                r_s2_zero  <= (w_res == '0);
            end
        end
    end

    assign out_valid = r_s2_valid;
    assign d_out     = r_s2_d;
    assign carry     = r_s2_carry;
    assign zero      = r_s2_zero;

endmodule
